// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared state encoding and default widths for pipeline stage regs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int C_DATA_W_DEFAULT = 64;
    localparam int C_CNT_W_DEFAULT  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module : pipe_stage_reg
// Brief  : Valid/ready pipeline register with one skid entry, stall, flush
//          and a saturating count of entries discarded by flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = C_DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0] RESET_DATA  = '0,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int                CNT_W       = C_CNT_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    localparam logic [CNT_W+1:0] C_CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_e              state_q,    state_d;
    logic [DATA_W-1:0]   main_q,     main_d;
    logic [DATA_W-1:0]   skid_q,     skid_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                w_accept;
    logic                w_emit;
    logic                w_flush;
    logic [1:0]          w_held;
    logic [CNT_W+1:0]    w_cnt_sum;

    // in_ready depends only on local state so no ready path crosses the stage
    assign in_ready_o  = start_i & ~stall_i & (state_q != FULL);
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
    assign drop_cnt_o  = drop_cnt_q;

    assign w_flush  = start_i & flush_i;
    assign w_accept = in_valid_i & in_ready_o & ~flush_i;
    assign w_emit   = out_valid_o & out_ready_i & start_i & ~stall_i & ~flush_i;

    always_comb begin
        w_held = 2'd0;
        case (state_q)
            ONE:     w_held = 2'd1;
            FULL:    w_held = 2'd2;
            default: w_held = 2'd0;
        endcase
    end

    assign w_cnt_sum = {2'b00, drop_cnt_q}
                     + {{CNT_W{1'b0}}, w_held}
                     + {{(CNT_W+1){1'b0}}, in_valid_i};

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        drop_cnt_d = drop_cnt_q;

        if (w_flush) begin
            state_d    = EMPTY;
            main_d     = BUBBLE_DATA;
            drop_cnt_d = (w_cnt_sum > C_CNT_MAX) ? C_CNT_MAX[CNT_W-1:0]
                                                 : w_cnt_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_accept) begin
                        state_d = ONE;
                        main_d  = in_data_i;
                    end
                end
                ONE: begin
                    if (w_accept && w_emit) begin
                        main_d  = in_data_i;
                    end else if (w_emit) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_DATA;
                    end else if (w_accept) begin
                        state_d = FULL;
                        skid_d  = in_data_i;
                    end
                end
                FULL: begin
                    if (w_emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= EMPTY;
            main_q     <= RESET_DATA;
            skid_q     <= RESET_DATA;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module : tb_pipe_stage_reg
// Brief  : Scoreboard bench for pipe_stage_reg against a two-deep FIFO model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int             DW    = 64;
    localparam logic [DW-1:0]  RST_D = 64'hDEAD_BEEF_0000_0001;
    localparam logic [DW-1:0]  BUB_D = 64'h0000_0000_0000_0013;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic          out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          in_ready, out_valid, in_ready2, out_valid2;
    logic [DW-1:0] out_data, out_data2;
    logic [7:0]    drop_cnt;
    logic [1:0]    drop_cnt2;

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RST_D), .BUBBLE_DATA(BUB_D), .CNT_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .stall_i(stall),
        .flush_i(flush), .drop_cnt_o(drop_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_DATA(RST_D), .BUBBLE_DATA(BUB_D), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready2), .in_data_i(in_data), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .out_data_o(out_data2), .stall_i(stall),
        .flush_i(flush), .drop_cnt_o(drop_cnt2)
    );

    int            vectors = 0;
    int            errors  = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned   total_drops = 0;
    logic [DW-1:0] empty_data  = RST_D;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check visible state against the model, then
    // advance the model (the monitor handles emissions).
    task automatic step(input bit r, input bit s, input bit v, input logic [DW-1:0] d,
                        input bit rd, input bit st, input bit fl);
        bit m_ready;
        @(negedge clk);
        rst_n = r; start = s; in_valid = v; in_data = d;
        out_ready = rd; stall = st; flush = fl;
        #1;
        m_ready = s && !st && (exp_q.size() < 2);
        check("in_ready",  {63'd0, in_ready},  {63'd0, m_ready});
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() == 0)
            check("empty_data", out_data, empty_data);
        check("drop_cnt8", {56'd0, drop_cnt},  64'(total_drops > 255 ? 255 : total_drops));
        check("drop_cnt2", {62'd0, drop_cnt2}, 64'(total_drops > 3 ? 3 : total_drops));
        if (!r) begin
            exp_q.delete();
            total_drops = 0;
            empty_data  = RST_D;
        end else if (s && fl) begin
            total_drops += exp_q.size() + (v ? 1 : 0);
            exp_q.delete();
            empty_data = BUB_D;
        end else if (v && m_ready) begin
            exp_q.push_back(d);
            empty_data = BUB_D;
        end
    endtask

    // Monitor: every DUT emission must match the oldest outstanding entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && start && !stall && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL emit_unexpected: got %h expected no emission", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        repeat (2) @(posedge clk);

        // reset-state observation, then single pass-through
        step(1, 1, 0, '0, 0, 0, 0);
        step(1, 1, 1, 64'h0000_0004_0000_0013, 1, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);

        // fill to FULL with downstream blocked, then drain in order
        step(1, 1, 1, 64'hAAAA_0000_0000_000A, 0, 0, 0);
        step(1, 1, 1, 64'hBBBB_0000_0000_000B, 0, 0, 0);
        step(1, 1, 1, 64'hCCCC_0000_0000_000C, 0, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);

        // FULL plus incoming entry under flush: three dropped
        step(1, 1, 1, 64'h1, 0, 0, 0);
        step(1, 1, 1, 64'h2, 0, 0, 0);
        step(1, 1, 1, 64'h3, 0, 0, 1);
        step(1, 1, 0, '0, 0, 0, 0);

        // stall holds a single entry, then releases it exactly once
        step(1, 1, 1, 64'h5555_6666_7777_8888, 0, 0, 0);
        repeat (3) step(1, 1, 1, 64'h9, 1, 1, 0);
        step(1, 1, 0, '0, 1, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);

        // start low ignores flush; repeated flushes saturate the narrow counter
        step(1, 1, 1, 64'h77, 0, 0, 0);
        step(1, 0, 1, 64'h88, 1, 0, 1);
        step(1, 0, 1, 64'h99, 1, 1, 1);
        repeat (4) step(1, 1, 1, rnd64(), 1, 1, 1);
        step(1, 1, 0, '0, 0, 0, 0);

        // reset mid-operation discards held entries without counting
        step(1, 1, 1, 64'hF1, 0, 0, 0);
        step(1, 1, 1, 64'hF2, 0, 0, 0);
        step(0, 1, 1, 64'hF3, 1, 0, 1);
        step(1, 1, 0, '0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 1) != 0),
                 rnd64(),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 19) == 0));
        end
        step(1, 1, 0, '0, 1, 0, 0);
        step(1, 1, 0, '0, 1, 0, 0);
        step(1, 1, 0, '0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
